// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one QSPI SRAM controller between the host
// bridge (SPI/UART) and the Levenshtein engine, with a per-request timeout.
module sram_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // host requester
  input  logic                  h_req,
  input  logic                  h_we,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [7:0]            h_wdata,
  output logic                  h_ack,
  output logic                  h_err,
  output logic [7:0]            h_rdata,
  // engine requester
  input  logic                  e_req,
  input  logic                  e_we,
  input  logic [ADDR_WIDTH-1:0] e_addr,
  input  logic [7:0]            e_wdata,
  output logic                  e_ack,
  output logic                  e_err,
  output logic [7:0]            e_rdata,
  // SRAM controller side
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [7:0]            m_wdata,
  input  logic                  m_ack,
  input  logic [7:0]            m_rdata,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wdata;
  } cmd_t;

  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT_CYCLES);

  state_e      state_q;
  cmd_t        cmd_q;
  logic        m_req_q;
  logic [1:0]  grant_q;
  logic [15:0] cnt_q;
  logic        owner_e_q;
  logic        last_e_q;
  logic        h_ack_q, e_ack_q;
  logic        h_err_q, e_err_q;
  logic [7:0]  h_rdata_q, e_rdata_q;

  logic        pick_e;
  cmd_t        win_cmd_d;
  logic        finish_d;
  logic [7:0]  rsp_data_d;

  // Engine wins when alone, or on a tie when the host was served last.
  assign pick_e    = e_req & (~h_req | ~last_e_q);
  assign win_cmd_d = pick_e ? {e_we, e_addr, e_wdata} : {h_we, h_addr, h_wdata};

  // An ack on the expiry cycle still counts as success.
  assign finish_d   = m_ack | (cnt_q <= 16'd1);
  assign rsp_data_d = (m_ack & ~cmd_q.we) ? m_rdata : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      m_req_q   <= 1'b0;
      grant_q   <= 2'b00;
      cnt_q     <= 16'd0;
      owner_e_q <= 1'b0;
      last_e_q  <= 1'b1;
      h_ack_q   <= 1'b0;
      e_ack_q   <= 1'b0;
      h_err_q   <= 1'b0;
      e_err_q   <= 1'b0;
      h_rdata_q <= 8'h00;
      e_rdata_q <= 8'h00;
    end else begin
      h_ack_q <= 1'b0;
      e_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (h_req | e_req) begin
            cmd_q     <= win_cmd_d;
            owner_e_q <= pick_e;
            grant_q   <= pick_e ? 2'b10 : 2'b01;
            m_req_q   <= 1'b1;
            cnt_q     <= TO_LOAD;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q - 16'd1;
          if (finish_d) begin
            m_req_q <= 1'b0;
            grant_q <= 2'b00;
            state_q <= DONE;
            if (owner_e_q) begin
              e_ack_q   <= 1'b1;
              e_rdata_q <= rsp_data_d;
              e_err_q   <= ~m_ack;
            end else begin
              h_ack_q   <= 1'b1;
              h_rdata_q <= rsp_data_d;
              h_err_q   <= ~m_ack;
            end
          end
        end
        DONE: begin
          last_e_q <= owner_e_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = cmd_q.we;
  assign m_addr  = cmd_q.addr;
  assign m_wdata = cmd_q.wdata;
  assign grant   = grant_q;
  assign h_ack   = h_ack_q;
  assign h_err   = h_err_q;
  assign h_rdata = h_rdata_q;
  assign e_ack   = e_ack_q;
  assign e_err   = e_err_q;
  assign e_rdata = e_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: directed vector table, reset corners, then randomized
// traffic checked against a transaction-level round-robin/timeout model.
module tb_sram_arbiter;
  localparam int AW = 24;
  localparam int TO = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } cmd_t;

  typedef struct {
    bit         hr, er;
    cmd_t       hcmd, ecmd;
    int         k;
    logic [7:0] rd;
    logic [1:0] eg;
    logic [7:0] erd;
    bit         eerr;
    int         elen;
  } vec_t;

  logic clk = 1'b0, rst;
  logic h_req, h_we, e_req, e_we, m_ack;
  logic [AW-1:0] h_addr, e_addr;
  logic [7:0] h_wdata, e_wdata, m_rdata;
  logic h_ack, h_err, e_ack, e_err, m_req, m_we;
  logic [7:0] h_rdata, e_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [1:0] grant;

  sram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_err(h_err), .h_rdata(h_rdata),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_ack(e_ack), .e_err(e_err), .e_rdata(e_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // model state
  bit ph, pe, last_e;
  cmd_t hc, ec;
  logic [7:0] mh_rd, me_rd;
  bit mh_err, me_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = AW'($urandom);
    c.wdata = 8'($urandom);
    return c;
  endfunction

  task automatic set_h(input cmd_t c);
    h_req = 1'b1; h_we = c.we; h_addr = c.addr; h_wdata = c.wdata; hc = c; ph = 1'b1;
  endtask

  task automatic set_e(input cmd_t c);
    e_req = 1'b1; e_we = c.we; e_addr = c.addr; e_wdata = c.wdata; ec = c; pe = 1'b1;
  endtask

  task automatic model_reset();
    ph = 0; pe = 0; last_e = 1;
    mh_rd = 0; me_rd = 0; mh_err = 0; me_err = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_req"}, 32'(m_req), 32'(0));
    chk({tag, "_m_we"}, 32'(m_we), 32'(0));
    chk({tag, "_m_addr"}, 32'(m_addr), 32'(0));
    chk({tag, "_m_wdata"}, 32'(m_wdata), 32'(0));
    chk({tag, "_grant"}, 32'(grant), 32'(0));
    chk({tag, "_acks"}, 32'({h_ack, e_ack}), 32'(0));
    chk({tag, "_errs"}, 32'({h_err, e_err}), 32'(0));
    chk({tag, "_rdatas"}, 32'({h_rdata, e_rdata}), 32'(0));
  endtask

  // Called at #1 into an IDLE cycle with requests already applied. Plays the
  // controller (acks in ISSUE cycle k; k > TO means never) and checks the result.
  task automatic serve(input int k, input logic [7:0] rd, input bit noise, input bit spur,
                       output logic [1:0] g, output logic [7:0] ord, output logic oerr,
                       output int len);
    bit win_e, acked, wwe;
    cmd_t wc;
    logic [7:0] erd;
    if (ph && pe) win_e = !last_e;
    else          win_e = pe;
    wc = win_e ? ec : hc;
    step();
    g = grant;
    chk("grant", 32'(grant), win_e ? 32'(2) : 32'(1));
    chk("m_req_start", 32'(m_req), 32'(1));
    chk("m_addr", 32'(m_addr), 32'(wc.addr));
    chk("m_we", 32'(m_we), 32'(wc.we));
    chk("m_wdata", 32'(m_wdata), 32'(wc.wdata));
    len = 0;
    for (int i = 1; i <= 20; i++) begin
      if (!m_req) break;
      len = i;
      if (i == k) begin m_ack = 1'b1; m_rdata = rd; end
      else begin m_ack = 1'b0; m_rdata = 8'($urandom); end
      if (noise && i == 2) begin
        if (win_e && !ph && $urandom_range(0, 1) == 1) set_h(rand_cmd());
        if (!win_e && !pe && $urandom_range(0, 1) == 1) set_e(rand_cmd());
      end
      step();
      m_ack = 1'b0;
      chk("m_cmd_stable", 32'({m_we, m_wdata}), 32'({wc.we, wc.wdata}));
    end
    acked = (k >= 1 && k <= TO);
    wwe = wc.we;
    erd = (acked && !wwe) ? rd : 8'h00;
    chk("issue_len", 32'(len), acked ? 32'(k) : 32'(TO));
    if (win_e) begin me_rd = erd; me_err = !acked; end
    else       begin mh_rd = erd; mh_err = !acked; end
    last_e = win_e;
    chk("done_m_req", 32'(m_req), 32'(0));
    chk("done_grant", 32'(grant), 32'(0));
    chk("done_acks", 32'({h_ack, e_ack}), win_e ? 32'(1) : 32'(2));
    chk("h_rsp", 32'({h_err, h_rdata}), 32'({mh_err, mh_rd}));
    chk("e_rsp", 32'({e_err, e_rdata}), 32'({me_err, me_rd}));
    ord  = win_e ? e_rdata : h_rdata;
    oerr = win_e ? e_err : h_err;
    if (spur) begin m_ack = 1'b1; m_rdata = 8'hEE; end
    step();
    m_ack = 1'b0;
    chk("ack_pulse", 32'({h_ack, e_ack}), 32'(0));
    chk("hold_rsp", 32'({h_err, h_rdata, e_err, e_rdata}), 32'({mh_err, mh_rd, me_err, me_rd}));
    if (win_e) begin e_req = 1'b0; pe = 0; end
    else       begin h_req = 1'b0; ph = 0; end
  endtask

  vec_t tbl[8];

  initial begin
    logic [1:0] g;
    logic [7:0] ord;
    logic oerr;
    int len;

    tbl[0] = '{1, 1, '{0, 24'h20, 0},    '{0, 24'h30, 0},    2,  8'h11, 2'b01, 8'h11, 0, 2};
    tbl[1] = '{1, 0, '{0, 24'h21, 0},    '{0, 24'h0, 0},     3,  8'h22, 2'b10, 8'h22, 0, 3};
    tbl[2] = '{0, 1, '{0, 24'h0, 0},     '{0, 24'h31, 0},    1,  8'h33, 2'b01, 8'h33, 0, 1};
    tbl[3] = '{1, 0, '{0, 24'h10, 0},    '{0, 24'h0, 0},     2,  8'h44, 2'b10, 8'h44, 0, 2};
    tbl[4] = '{0, 0, '{0, 24'h0, 0},     '{0, 24'h0, 0},     4,  8'hA5, 2'b01, 8'hA5, 0, 4};
    tbl[5] = '{0, 1, '{0, 24'h0, 0},     '{1, 24'h200, 8'h3C}, 3, 8'hFF, 2'b10, 8'h00, 0, 3};
    tbl[6] = '{1, 0, '{0, 24'h40, 0},    '{0, 24'h0, 0},     99, 8'h77, 2'b01, 8'h00, 1, 8};
    tbl[7] = '{1, 0, '{0, 24'h41, 0},    '{0, 24'h0, 0},     8,  8'h5A, 2'b01, 8'h5A, 0, 8};

    rst = 1'b1; m_ack = 1'b0; m_rdata = 8'h00;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = 0;
    e_req = 0; e_we = 0; e_addr = '0; e_wdata = 0;
    model_reset();
    step(); step();
    chk_reset_outputs("rst");
    rst = 1'b0;
    step();

    // reset two cycles into ISSUE abandons the request
    set_h('{0, 24'h50, 8'h00});
    step();
    chk("pre_rst_m_req", 32'(m_req), 32'(1));
    step();
    #2 rst = 1'b1;
    #1 chk_reset_outputs("mid_rst");
    h_req = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_quiet", 32'({h_ack, m_req}), 32'(0));
    end

    // directed vector table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].hr) set_h(tbl[i].hcmd);
      if (tbl[i].er) set_e(tbl[i].ecmd);
      serve(tbl[i].k, tbl[i].rd, 1'b0, tbl[i].k > TO, g, ord, oerr, len);
      chk($sformatf("vec%0d_grant", i), 32'(g), 32'(tbl[i].eg));
      chk($sformatf("vec%0d_rdata", i), 32'(ord), 32'(tbl[i].erd));
      chk($sformatf("vec%0d_err", i), 32'(oerr), 32'(tbl[i].eerr));
      chk($sformatf("vec%0d_len", i), 32'(len), 32'(tbl[i].elen));
    end

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (!ph && $urandom_range(0, 1) == 1) set_h(rand_cmd());
      if (!pe && $urandom_range(0, 1) == 1) set_e(rand_cmd());
      if (!ph && !pe) begin
        if ($urandom_range(0, 1) == 1) set_h(rand_cmd());
        else                           set_e(rand_cmd());
      end
      serve(int'($urandom_range(1, 10)), 8'($urandom), 1'b1,
            $urandom_range(0, 3) == 0, g, ord, oerr, len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
